// File: rtl/biriscv_trace_buffer_if.sv
// rtl/biriscv_trace_buffer_if.sv - trace drain stream between the capture buffer and a trace sink
interface biriscv_trace_buffer_if #(
    parameter int LANE_W = 1,
    parameter int TS_W   = 16
);
    logic              out_valid_o;
    logic              out_ready_i;
    logic [31:0]       out_pc_o;
    logic [31:0]       out_opcode_o;
    logic [LANE_W-1:0] out_lane_o;
    logic [TS_W-1:0]   out_ts_o;

    modport master (
        output out_valid_o,
        output out_pc_o,
        output out_opcode_o,
        output out_lane_o,
        output out_ts_o,
        input  out_ready_i
    );

    modport slave (
        input  out_valid_o,
        input  out_pc_o,
        input  out_opcode_o,
        input  out_lane_o,
        input  out_ts_o,
        output out_ready_i
    );
endinterface

// File: rtl/biriscv_trace_buffer.sv
// rtl/biriscv_trace_buffer.sv - multi-lane retire-trace FIFO with timestamps and overflow accounting
// Optional control-flow/system opcode filter: BIRISCV_TRACE_FILTER_EN (adds filter_en_i).
module biriscv_trace_buffer #(
    parameter int NUM_LANES = 2,
    parameter int DEPTH     = 16,
    parameter int TS_W      = 16,
    parameter int DROP_W    = 16,
    localparam int LANE_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int LVL_W    = $clog2(DEPTH) + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enable_i,
    input  logic                      flush_i,
`ifdef BIRISCV_TRACE_FILTER_EN
    input  logic                      filter_en_i,
`endif
    input  logic [NUM_LANES-1:0]      valid_i,
    input  logic [32*NUM_LANES-1:0]   pc_i,
    input  logic [32*NUM_LANES-1:0]   opcode_i,
    biriscv_trace_buffer_if.master    out_if,
    output logic [LVL_W-1:0]          level_o,
    output logic                      overflow_o,
    output logic [DROP_W-1:0]         drop_count_o
);

    localparam logic [LVL_W-1:0] DEPTH_L   = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [TS_W-1:0]  TS_ONE    = TS_W'(1);

    logic [31:0]       pc_mem   [DEPTH];
    logic [31:0]       op_mem   [DEPTH];
    logic [LANE_W-1:0] lane_mem [DEPTH];
    logic [TS_W-1:0]   ts_mem   [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q,  level_d;
    logic [TS_W-1:0]   ts_q,     ts_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_q,   drop_d;

    logic [NUM_LANES-1:0] lane_ok;
    logic [NUM_LANES-1:0] cap_mask;
    logic [PTR_W-1:0]     slot [NUM_LANES];
    logic [LVL_W-1:0]     cap_cnt;
    logic [LVL_W-1:0]     free_slots;
    logic                 fits;
    logic                 do_write;
    logic                 do_drop;
    logic                 head_valid;
    logic                 pop;
    logic [DROP_W:0]      drop_sum;

`ifdef BIRISCV_TRACE_FILTER_EN
    function automatic logic is_ctrl_flow(input logic [6:0] major);
        case (major)
            7'b1101111, 7'b1100111, 7'b1100011, 7'b1110011: is_ctrl_flow = 1'b1;
            default:                                        is_ctrl_flow = 1'b0;
        endcase
    endfunction
`endif

    // Filtered lanes look exactly like idle lanes, so they can never be counted as drops.
    always_comb begin
        lane_ok = '1;
`ifdef BIRISCV_TRACE_FILTER_EN
        if (filter_en_i) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                lane_ok[k] = is_ctrl_flow(opcode_i[32*k +: 7]);
            end
        end
`endif
        cap_mask = enable_i ? (valid_i & lane_ok) : '0;
    end

    // Captured lanes are packed into consecutive slots, oldest lane first.
    always_comb begin
        logic [LVL_W-1:0] run;
        run = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            slot[k] = wr_ptr_q + run[PTR_W-1:0];
            if (cap_mask[k]) begin
                run = run + LVL_ONE;
            end
        end
        cap_cnt = run;
    end

    assign head_valid = (level_q != '0);
    assign free_slots = DEPTH_L - level_q;
    assign fits       = (cap_cnt <= free_slots);
    assign do_write   = !flush_i && fits && (cap_cnt != '0);
    assign do_drop    = !flush_i && !fits;
    assign pop        = !flush_i && head_valid && out_if.out_ready_i;
    assign drop_sum   = {1'b0, drop_q} + (DROP_W + 1)'(cap_cnt);

    always_comb begin
        ts_d       = ts_q + TS_ONE;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
        end else begin
            if (do_write) begin
                wr_ptr_d = wr_ptr_q + cap_cnt[PTR_W-1:0];
                level_d  = level_d + cap_cnt;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                level_d  = level_d - LVL_ONE;
            end
            if (do_drop) begin
                overflow_d = 1'b1;
                drop_d     = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ts_q       <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ts_q       <= ts_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Storage carries no reset; contents are only observable through level_q.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NUM_LANES; k++) begin
            if (do_write && cap_mask[k]) begin
                pc_mem[slot[k]]   <= pc_i[32*k +: 32];
                op_mem[slot[k]]   <= opcode_i[32*k +: 32];
                lane_mem[slot[k]] <= LANE_W'(k);
                ts_mem[slot[k]]   <= ts_q;
            end
        end
    end

    assign out_if.out_valid_o  = head_valid;
    assign out_if.out_pc_o     = pc_mem[rd_ptr_q];
    assign out_if.out_opcode_o = op_mem[rd_ptr_q];
    assign out_if.out_lane_o   = lane_mem[rd_ptr_q];
    assign out_if.out_ts_o     = ts_mem[rd_ptr_q];

    assign level_o      = level_q;
    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_q;

endmodule

// File: doc/biriscv_trace_buffer.md
Name: biriscv_trace_buffer

Overview:
- Multi-lane retire-trace capture buffer for the dual-issue core.
- Each cycle it takes up to NUM_LANES retired instructions (pc, opcode), stamps each with a free-running cycle timestamp and queues them in a DEPTH-entry FIFO.
- A valid/ready stream drains the FIFO one entry per cycle to a trace sink (sim monitor, trace port or debug RAM).
- Overflow is detected, counted and flagged; captured trace order is always preserved.

Parameters:
NUM_LANES, 2, retire lanes sampled per cycle (1..4)
DEPTH, 16, FIFO entries; power of two, >= NUM_LANES
TS_W, 16, timestamp width
DROP_W, 16, drop counter width

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous active-low reset
enable_i  input  1  capture enable
flush_i  input  1  synchronous flush of FIFO, overflow flag and drop counter
valid_i  input  NUM_LANES  per-lane retire valid; lane 0 is oldest
pc_i  input  32*NUM_LANES  per-lane pc, lane k at [32k+31:32k]
opcode_i  input  32*NUM_LANES  per-lane opcode, same packing
out_valid_o  output  1  head entry valid
out_ready_i  input  1  sink accepts head
out_pc_o  output  32  head pc
out_opcode_o  output  32  head opcode
out_lane_o  output  max(1,clog2(NUM_LANES))  head source lane
out_ts_o  output  TS_W  head timestamp
level_o  output  clog2(DEPTH)+1  current occupancy
overflow_o  output  1  sticky: at least one entry dropped since reset/flush
drop_count_o  output  DROP_W  dropped-instruction count, saturating

Behaviour:
- Reset (rst_i low, async): FIFO empty, rd/wr pointers 0, level_o=0, out_valid_o=0, overflow_o=0, drop_count_o=0, timestamp=0. Head data outputs are don't-care while out_valid_o=0. Reset mid-stream discards all contents.
- Timestamp: increments by 1 every cycle, wraps 2^TS_W-1 -> 0. Not affected by enable_i or flush_i.
- Capture: when enable_i=1, the set V = lanes with valid_i=1 (after optional filter). Let n=|V| and free=DEPTH-level at start of cycle.
  - If n <= free: all n entries are written in ascending lane order to consecutive slots, each with the current timestamp and its lane index.
  - If n > free: none of this cycle's lanes are written (all-or-nothing, preserves per-cycle order). drop_count_o += n, saturating at 2^DROP_W-1. overflow_o is set.
  - A pop in the same cycle does not add to free.
- When enable_i=0: nothing is captured and nothing is counted.
- Output: first-word-fall-through. An entry written in cycle N is visible at the head in cycle N+1. Pop occurs when out_valid_o && out_ready_i. Head fields are stable while out_valid_o=1 and out_ready_i=0.
- level_o = level + writes - pop, updated each cycle. It never exceeds DEPTH. Pointers wrap modulo DEPTH.
- flush_i=1 (synchronous, highest priority): next cycle the FIFO is empty, overflow_o=0 and drop_count_o=0. Same-cycle captures and pops are discarded and are not counted as drops.
- Empty with out_ready_i=1: no pop, no state change.

Optional Feature:
- Macro: BIRISCV_TRACE_FILTER_EN.
- When defined: a lane is captured only if opcode[6:0] is a control-flow or system instruction: 1101111 jal, 1100111 jalr, 1100011 branch, 1110011 system (ecall/ebreak/eret/csr). Filtered lanes are treated as valid_i=0 and never count as drops. Adds input filter_en_i (1 bit); the filter applies only when filter_en_i=1.
- When undefined: every valid lane is captured and the filter_en_i port does not exist.

Test Plan:
- Reset, then lane0 pc=0x80000000 op=0x00000013 and lane1 pc=0x80000004 op=0x00100093 in one cycle, out_ready_i=0 -> next cycle level_o=2; head shows pc 0x80000000, lane 0, ts = capture-cycle ts. After one pop the head is pc 0x80000004, lane 1, same ts.
- DEPTH=16, out_ready_i=0: capture 15 entries, then a cycle with both lanes valid -> nothing written, level_o=15, drop_count_o=2, overflow_o=1. Next cycle with lane0 only -> written, level_o=16.
- Full FIFO, out_ready_i=1, both lanes valid in the same cycle -> pop happens, capture dropped, level_o=15, drop_count_o += 2.
- Stream 100 single-lane entries with out_ready_i=1 continuously -> each appears exactly one cycle after capture, in order. ts increments by 1 per entry. level_o stays at most 1.
- flush_i asserted with level_o=7, overflow_o=1, and both lanes valid -> next cycle level_o=0, out_valid_o=0, overflow_o=0, drop_count_o=0.
- With BIRISCV_TRACE_FILTER_EN and filter_en_i=1: lane0 op=0x00000013 (addi), lane1 op=0x0000006F (jal) -> only the jal is captured, with out_lane_o=1, and drop_count_o is unchanged.
